// File: rtl/dlfloat_pkg.sv
// Shared types and constants for the DLFloat16 operand loader: command
// encodings, the queued entry layout and the frame-parser state encoding.
package dlfloat_pkg;

    localparam int DLF_W = 16;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_MAC = 2'b01;
    localparam logic [1:0] CMD_CLR = 2'b10;
    localparam logic [1:0] CMD_RSV = 2'b11;

    localparam logic [DLF_W-1:0] DLF_NAN = 16'hFFFF;

    typedef struct packed {
        logic             clr;
        logic [DLF_W-1:0] a;
        logic [DLF_W-1:0] b;
    } dlf_entry_t;

    localparam int ENTRY_W = $bits(dlf_entry_t);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_LO,
        ST_A_HI,
        ST_B_LO,
        ST_B_HI
    } ld_state_t;

endpackage

// File: rtl/dlfloat_op_fifo.sv
// Synchronous FIFO for parsed MAC entries. The head is read from storage,
// so a push into an empty FIFO shows up one cycle later.
module dlfloat_op_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dlfloat_operand_loader.sv
// Byte-serial command parser feeding the DLFloat16 MAC through a small FIFO,
// with a mid-frame idle timeout and sticky protocol error flags.
//
//   state   | meaning
//   IDLE    | waiting for a command byte
//   A_LO    | waiting for a[7:0]
//   A_HI    | waiting for a[15:8]
//   B_LO    | waiting for b[7:0]
//   B_HI    | waiting for b[15:8]; completing byte pushes the entry
module dlfloat_operand_loader
    import dlfloat_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic        op_clr,
    output logic        err_cmd,
    output logic        err_to,
    output logic        busy
);

    ld_state_t        state_q;
    logic [DLF_W-1:0] a_q;
    logic [7:0]       b_lo_q;
    logic [TO_W-1:0]  to_q;
    logic             err_cmd_q;
    logic             err_to_q;

    logic             xfer;
    logic             push;
    logic             expire;
    logic             fifo_full;
    logic             fifo_empty;
    logic [1:0]       cmd;
    dlf_entry_t       push_entry;
    dlf_entry_t       head;
    logic [ENTRY_W-1:0] head_bits;

    assign cmd = in_data[1:0];

    // Only a byte that would complete an entry can be stalled by a full FIFO.
    assign in_ready = !(fifo_full &&
                        ((state_q == ST_B_HI) ||
                         ((state_q == ST_IDLE) && (cmd == CMD_CLR))));
    assign xfer   = in_valid && in_ready;
    assign push   = xfer && ((state_q == ST_B_HI) ||
                             ((state_q == ST_IDLE) && (cmd == CMD_CLR)));
    assign expire = (state_q != ST_IDLE) && !in_valid &&
                    (to_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        push_entry = '0;
        if (state_q == ST_B_HI) begin
            push_entry.clr = 1'b0;
            push_entry.a   = a_q;
            push_entry.b   = {in_data, b_lo_q};
        end else begin
            push_entry.clr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_lo_q    <= '0;
            to_q      <= '0;
            err_cmd_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) || in_valid || expire) begin
                to_q <= '0;
            end else begin
                to_q <= to_q + TO_W'(1);
            end

            if (expire) begin
                state_q  <= ST_IDLE;
                a_q      <= '0;
                b_lo_q   <= '0;
                err_to_q <= 1'b1;
            end else if (xfer) begin
                case (state_q)
                    ST_IDLE: begin
                        if (cmd == CMD_MAC) begin
                            state_q <= ST_A_LO;
                        end
                        if (cmd == CMD_RSV) begin
                            err_cmd_q <= 1'b1;
                        end
                    end
                    ST_A_LO: begin
                        a_q[7:0] <= in_data;
                        state_q  <= ST_A_HI;
                    end
                    ST_A_HI: begin
                        a_q[15:8] <= in_data;
                        state_q   <= ST_B_LO;
                    end
                    ST_B_LO: begin
                        b_lo_q  <= in_data;
                        state_q <= ST_B_HI;
                    end
                    ST_B_HI: begin
                        a_q     <= '0;
                        b_lo_q  <= '0;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    dlfloat_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (op_ready),
        .data_o  (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head     = head_bits;
    assign op_valid = !fifo_empty;
    assign op_a     = op_valid ? head.a : '0;
    assign op_b     = op_valid ? head.b : '0;
    assign op_clr   = op_valid && head.clr;
    assign err_cmd  = err_cmd_q;
    assign err_to   = err_to_q;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_dlfloat_operand_loader.sv
// Scoreboard bench for the operand loader: stimulus queues expected entries,
// a negedge monitor pops and compares each entry the MAC side consumes.
module tb_dlfloat_operand_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_clr;
    logic        err_cmd;
    logic        err_to;
    logic        busy;

    int checks = 0;
    int failures = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_got;
    logic [32:0] mon_exp;

    dlfloat_operand_loader #(
        .DEPTH   (2),
        .TIMEOUT (4),
        .TO_W    (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_clr   (op_clr),
        .err_cmd  (err_cmd),
        .err_to   (err_to),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && op_valid && op_ready) begin
            mon_got = {op_clr, op_a, op_b};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_entry actual=%h required=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL entry actual=%h required=%h", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                n++;
                if (n > 100) begin
                    checks++;
                    failures++;
                    $display("FAIL send_timeout actual=stalled required=accept byte=%h", b);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic mac(input logic [15:0] a, input logic [15:0] b);
        send(8'h01);
        send(a[7:0]);
        send(a[15:8]);
        send(b[7:0]);
        exp_q.push_back({1'b0, a, b});
        send(b[15:8]);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_no_extra_valid"}, {31'd0, op_valid}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_outputs", {op_valid, op_clr, err_cmd, err_to, busy, op_a, op_b}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single MAC frame
        op_ready = 1'b1;
        mac(16'h3E00, 16'h3E00);
        drain("t1");
        chk("t1_err_cmd", {31'd0, err_cmd}, 0);

        // 2: clear request visible on the cycle after its byte
        exp_q.push_back({1'b1, 16'h0000, 16'h0000});
        send(8'h02);
        chk("t2_valid_next_cycle", {30'd0, op_valid, op_clr}, 32'h3);
        drain("t2");

        // 3: backpressure with a full FIFO
        op_ready = 1'b0;
        mac(16'h1111, 16'h2222);
        mac(16'h3333, 16'h4444);
        send(8'h01);
        send(8'h55);
        send(8'h55);
        send(8'h66);
        exp_q.push_back({1'b0, 16'h5555, 16'h6666});
        in_valid = 1'b1;
        in_data  = 8'h66;
        @(negedge clk);
        chk("t3_in_ready_low", {31'd0, in_ready}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t3_in_ready_still_low", {31'd0, in_ready}, 0);
        chk("t3_head_stable", {op_a, op_b}, 32'h1111_2222);
        chk("t3_no_timeout_on_stall", {31'd0, err_to}, 0);
        @(posedge clk);
        #1;
        op_ready = 1'b1;
        send(8'h66);
        drain("t3");

        // 4: reserved command, then all-ones operands
        send(8'h03);
        chk("t4_err_cmd", {31'd0, err_cmd}, 1);
        chk("t4_busy_idle", {31'd0, busy}, 0);
        mac(16'hFFFF, 16'hFFFF);
        drain("t4");

        // 5: timeout mid-frame
        send(8'h01);
        send(8'h12);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_before_expiry", {30'd0, err_to, busy}, 32'h1);
        @(posedge clk);
        #1;
        chk("t5_expired", {30'd0, err_to, busy}, 32'h2);
        mac(16'h1234, 16'h5678);
        drain("t5");
        chk("t5_err_cmd_sticky", {31'd0, err_cmd}, 1);

        // 6: reset mid-frame with a queued entry
        op_ready = 1'b0;
        mac(16'hAAAA, 16'hBBBB);
        send(8'h01);
        send(8'h34);
        send(8'h12);
        chk("t6_pre_reset_valid", {30'd0, op_valid, busy}, 32'h3);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_rst_outputs", {op_valid, op_clr, err_cmd, err_to, busy, op_a, op_b}, 0);
        chk("t6_rst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        op_ready = 1'b1;
        @(posedge clk);
        #1;
        mac(16'hABCD, 16'hEF01);
        drain("t6");
        chk("t6_final_idle", {29'd0, busy, err_cmd, err_to}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dlfloat_operand_loader.md
Name: dlfloat_operand_loader

Overview:
- Upstream front-end for the DLFloat16 MAC. Parses a byte-serial command stream from the chip pins (valid/ready) into complete operand pairs {a, b} and accumulator-clear requests.
- Buffers parsed entries in a small FIFO and presents them to the MAC input stage over a valid/ready handshake.
- Aborts partial frames after a programmable idle timeout and reports protocol errors through sticky flags.

Parameters:
- DEPTH, 2, FIFO entries; power of two, at least 2.
- TIMEOUT, 255, idle cycles allowed mid-frame before abort; range 1..65535.
- TO_W, 16, timeout counter width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data holds a byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts the byte this cycle.
- op_valid  out  1  FIFO head is valid.
- op_ready  in  1  MAC stage consumes the head.
- op_a  out  16  operand A of the FIFO head.
- op_b  out  16  operand B of the FIFO head.
- op_clr  out  1  head is a clear request; op_a and op_b read 0.
- err_cmd  out  1  sticky: reserved command received.
- err_to  out  1  sticky: frame aborted on timeout.
- busy  out  1  FSM not in IDLE, or FIFO not empty.

Behaviour:
- Reset (asynchronous): FSM enters IDLE, FIFO empties, timeout counter goes to 0, both sticky flags clear. All outputs read 0 except in_ready, which reads 1.
- A byte transfers on any cycle where in_valid && in_ready.
- Command byte, bits [1:0]:
  - 00 NOP: no payload.
  - 01 MAC: 4 payload bytes follow, in order a[7:0], a[15:8], b[7:0], b[15:8].
  - 10 CLR: no payload.
  - 11 reserved: sets err_cmd; the byte is dropped.
  - Bits [7:2] are ignored.
- FSM states and transitions (each step on a transferred byte):
  - IDLE: MAC goes to A_LO; CLR pushes {clr=1, a=0, b=0} and stays in IDLE; NOP and reserved stay in IDLE.
  - A_LO -> A_HI -> B_LO -> B_HI.
  - B_HI pushes {clr=0, a, b} and returns to IDLE.
  - Partial bytes are held in internal shadow registers, never on op_a/op_b.
- in_ready is 0 only when FIFO full AND the FSM is in B_HI, or is in IDLE with in_data[1:0]==10. It is 1 otherwise, so non-completing bytes are never stalled.
- FIFO push and pop in the same cycle are both allowed when full, and occupancy stays the same.
  - When empty, a push becomes visible on op_valid one cycle later; there is no fall-through.
  - Ordering is strict FIFO.
  - op_a, op_b and op_clr are stable while op_valid && !op_ready.
- Timeout:
  - The counter runs only in states other than IDLE.
  - It resets to 0 on every transferred byte, and on any cycle where in_valid is high (a stall is not idle).
  - When it reaches TIMEOUT: FSM returns to IDLE, shadow registers clear, err_to sets, and nothing is pushed.
  - A byte transferring in the same cycle as expiry takes priority: the timeout is cancelled and the byte is processed normally.
- Operands are opaque 16-bit values; 16'hFFFF and 0 pass through unmodified.
- Sticky flags clear only on reset.
- Reset mid-frame discards the partial frame and all FIFO contents.

Decomposition:
- Package dlfloat_pkg holds:
  - DLF_W=16.
  - Command encodings CMD_NOP, CMD_MAC, CMD_CLR, CMD_RSV.
  - DLF_NAN=16'hFFFF.
  - Packed entry type {clr, a[15:0], b[15:0]} of 33 bits.
  - FSM state enum.
- One sub-module, dlfloat_op_fifo: a synchronous FIFO parameterised by DEPTH and width 33, with full/empty flags and an asynchronous reset.

Test Plan:
1. Reset, then send 01,00,3E,00,3E with op_ready=1 -> exactly one pulse of op_valid with op_a=3E00, op_b=3E00, op_clr=0; err_cmd=0.
2. Send 02 -> one entry with op_clr=1, op_a=0, op_b=0, visible on the cycle after the byte.
3. op_ready=0, send three MAC frames (DEPTH=2) -> in_ready drops on the third frame's B_HI byte. Raise op_ready -> entries drain in order and the third frame completes with no byte lost.
4. Send 03 followed by 01,FF,FF,FF,FF -> err_cmd=1, then one entry with op_a=FFFF, op_b=FFFF.
5. TIMEOUT=4: send 01,12, then idle 4 cycles -> err_to=1, no entry, FSM back in IDLE. A following full MAC frame parses correctly.
6. Assert rst_n low after 01,34,12 -> FIFO empty, busy=0, all outputs 0. A new frame afterwards is parsed from its command byte.
